// File: rtl/uart_prog_loader_if.sv
// Loader-side bundle: UART input, load control/status and the word-wide memory write port.
// master = the loader, slave = the CPU/memory side (or a bench).
interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              rx;
  logic              start;
  logic              loading;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              frame_err;

  modport master (
    input  rx, start,
    output loading, mem_we, mem_addr, mem_wdata, done, frame_err
  );

  modport slave (
    output rx, start,
    input  loading, mem_we, mem_addr, mem_wdata, done, frame_err
  );
endinterface

// File: rtl/uart_prog_loader.sv
// Serial program loader: 8N1 UART receiver feeding a little-endian word assembler
// that streams words sequentially into instruction/data memory while holding the CPU off.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 78,
  parameter int ADDR_W       = 14,
  parameter int TIMEOUT_CLKS = 10*CLKS_PER_BIT*4
) (
  input  logic                clock,
  input  logic                reset,
  uart_prog_loader_if.master  bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMR_W = $clog2(TIMEOUT_CLKS+1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT/2-1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT-1);
  localparam logic [TMR_W-1:0] TMO_CNT  = TMR_W'(TIMEOUT_CLKS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------- receiver ----------------
  logic             rx_meta, rx_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_valid, stop_bad;
  logic             enter_start;

  assign enter_start = (state == S_IDLE) && !rx_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stop_bad   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_bad   <= 1'b0;
      case (state)
        S_IDLE: if (!rx_s) begin
          state <= S_START;
          cnt   <= '0;
        end
        // mid-start-bit recheck rejects glitches shorter than half a bit
        S_START: if (cnt == HALF_CNT) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_s ? S_IDLE : S_DATA;
        end else cnt <= cnt + 1'b1;
        S_DATA: if (cnt == FULL_CNT) begin
          cnt     <= '0;
          rx_byte <= {rx_s, rx_byte[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= S_STOP;
        end else cnt <= cnt + 1'b1;
        default: if (cnt == FULL_CNT) begin
          cnt        <= '0;
          state      <= S_IDLE;
          byte_valid <= rx_s;
          stop_bad   <= !rx_s;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end

  // ---------------- loader ----------------
  logic              loading, mem_we, done, frame_err, armed;
  logic [ADDR_W-1:0] mem_addr, word_cnt;
  logic [31:0]       mem_wdata;
  logic [2:0][7:0]   lane_buf;
  logic [1:0]        lane;
  logic [TMR_W-1:0]  timer;
  logic              end_full, end_tmo;

  assign end_full = mem_we && (&mem_addr);
  assign end_tmo  = armed && (timer == TMO_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loading   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
      word_cnt  <= '0;
      lane_buf  <= '0;
      lane      <= '0;
      timer     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (loading) begin
        if (end_full || end_tmo) begin
          loading <= 1'b0;
          done    <= 1'b1;
        end else begin
          if (byte_valid) begin
            armed <= 1'b1;
            lane  <= lane + 2'd1;
            if (lane == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt;
              mem_wdata <= {rx_byte, lane_buf[2], lane_buf[1], lane_buf[0]};
              word_cnt  <= word_cnt + 1'b1;
            end else lane_buf[lane] <= rx_byte;
          end
          // timeout measured from the start edge of the most recent byte
          if (enter_start)                    timer <= '0;
          else if (armed && timer != TMO_CNT) timer <= timer + 1'b1;
        end
      end else if (bus.start) begin
        loading   <= 1'b1;
        done      <= 1'b0;
        frame_err <= 1'b0;
        armed     <= 1'b0;
        word_cnt  <= '0;
        lane      <= '0;
        timer     <= '0;
      end
      if (stop_bad) frame_err <= 1'b1;
    end
  end

  assign bus.loading   = loading;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.done      = done;
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected memory writes are queued as bytes are sent
// and checked against every mem_we strobe.
module tb_uart_prog_loader;
  localparam int CPB = 8;
  localparam int AW  = 2;
  localparam int TMO = 10*CPB*4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_prog_loader_if #(.ADDR_W(AW)) bus();

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CLKS(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int we_count = 0;
  int exp_we = 0;
  logic [AW+31:0] exp_q[$];

  // reference model of the loader
  bit        m_loading = 0;
  int        m_lane = 0;
  int        m_addr = 0;
  logic [31:0] m_word = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write monitor
  logic prev_we = 1'b0;
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      logic [AW+31:0] e;
      we_count++;
      chk("we_back2back", {63'd0, prev_we}, 64'd0);
      if (exp_q.size() == 0) chk("unexpected_we", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("mem_addr", 64'(bus.mem_addr), 64'(e[AW+31:32]));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(e[31:0]));
      end
    end
    prev_we = bus.mem_we;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    bus.start = 1'b1;
    if (!m_loading) begin
      m_loading = 1; m_lane = 0; m_addr = 0;
    end
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (m_loading && stop) begin
      m_word[8*m_lane +: 8] = b;
      m_lane++;
      if (m_lane == 4) begin
        exp_q.push_back({AW'(m_addr), m_word});
        exp_we++;
        m_lane = 0;
        m_addr++;
        if (m_addr == (1 << AW)) m_loading = 0;
      end
    end
    bus.rx = 1'b0; idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i]; idle(CPB);
    end
    bus.rx = stop; idle(CPB);
    bus.rx = 1'b1; idle(2*CPB);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 2*TMO) begin
      @(negedge clock); n++;
    end
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_loading"}, 64'(bus.loading), 64'd0);
    m_loading = 0;
  endtask

  initial begin
    reset = 1'b1; bus.rx = 1'b1; bus.start = 1'b0;
    // reset with rx toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); bus.rx = ~bus.rx;
    end
    chk("rst_loading", 64'(bus.loading), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ferr", 64'(bus.frame_err), 64'd0);
    @(negedge clock); bus.rx = 1'b1; reset = 1'b0;
    idle(20*CPB);
    chk("no_we_after_rst", 64'(we_count), 64'd0);

    // single word, then timeout
    pulse_start();
    chk("t2_loading", 64'(bus.loading), 64'd1);
    send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
    chk("t2_pending", 64'(exp_q.size()), 64'd0);
    chk("t2_still_loading", 64'(bus.loading), 64'd1);
    wait_done("t2");
    chk("t2_hold_addr", 64'(bus.mem_addr), 64'd0);
    chk("t2_hold_data", 64'(bus.mem_wdata), 64'h12345678);
    send_byte(8'h99, 1);  // not loading: dropped
    chk("t2_we_count", 64'(we_count), 64'(exp_we));

    // glitch and framing error
    pulse_start();
    chk("t3_done_clr", 64'(bus.done), 64'd0);
    @(negedge clock); bus.rx = 1'b0; idle(CPB/4); bus.rx = 1'b1;
    idle(3*CPB);
    chk("t3_glitch_ferr", 64'(bus.frame_err), 64'd0);
    send_byte(8'hA5, 0);
    chk("t3_ferr", 64'(bus.frame_err), 64'd1);
    chk("t3_loading", 64'(bus.loading), 64'd1);
    send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 1);
    chk("t3_pending", 64'(exp_q.size()), 64'd0);
    wait_done("t3");

    // partial word discarded at timeout
    pulse_start();
    chk("t4_ferr_clr", 64'(bus.frame_err), 64'd0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1);
    chk("t4_loading", 64'(bus.loading), 64'd1);
    wait_done("t4");
    idle(CPB);
    chk("t4_pending", 64'(exp_q.size()), 64'd0);
    chk("t4_we_count", 64'(we_count), 64'(exp_we));

    // capacity limit, no wrap
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h10 + 8'(i), 1);
      if (i == 15) begin
        chk("t5_done", 64'(bus.done), 64'd1);
        chk("t5_loading", 64'(bus.loading), 64'd0);
      end
    end
    chk("t5_pending", 64'(exp_q.size()), 64'd0);
    chk("t5_we_count", 64'(we_count), 64'(exp_we));

    // reset mid-load
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i), 1);
    @(negedge clock); reset = 1'b1;
    m_loading = 0; m_lane = 0; m_addr = 0;
    @(negedge clock);
    chk("t6_rst_loading", 64'(bus.loading), 64'd0);
    chk("t6_rst_addr", 64'(bus.mem_addr), 64'd0);
    reset = 1'b0;
    idle(2*CPB);
    pulse_start();
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    chk("t6_pending", 64'(exp_q.size()), 64'd0);
    wait_done("t6");
    chk("t6_we_count", 64'(we_count), 64'(exp_we));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
